// File: rtl/ctrl_pkg.sv
// Shared opcode constants, control-field encodings and the ID/EX control struct
// for the ctrl_pipe decode/hazard slice.
package ctrl_pkg;

  localparam int ALU_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [5:0] EXT_ITYPE_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_ITYPE       = 6'b010000;
  localparam logic [5:0] EXT_STYPE       = 6'b001000;
  localparam logic [5:0] EXT_BTYPE       = 6'b000100;
  localparam logic [5:0] EXT_UTYPE       = 6'b000010;
  localparam logic [5:0] EXT_JTYPE       = 6'b000001;

  localparam logic [ALU_W-1:0] ALU_NOP   = 5'h00;
  localparam logic [ALU_W-1:0] ALU_LUI   = 5'h01;
  localparam logic [ALU_W-1:0] ALU_AUIPC = 5'h02;
  localparam logic [ALU_W-1:0] ALU_ADD   = 5'h03;
  localparam logic [ALU_W-1:0] ALU_SUB   = 5'h04;
  localparam logic [ALU_W-1:0] ALU_BNE   = 5'h05;
  localparam logic [ALU_W-1:0] ALU_BLT   = 5'h06;
  localparam logic [ALU_W-1:0] ALU_BGE   = 5'h07;
  localparam logic [ALU_W-1:0] ALU_BLTU  = 5'h08;
  localparam logic [ALU_W-1:0] ALU_BGEU  = 5'h09;
  localparam logic [ALU_W-1:0] ALU_SLT   = 5'h0A;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 5'h0B;
  localparam logic [ALU_W-1:0] ALU_XOR   = 5'h0C;
  localparam logic [ALU_W-1:0] ALU_OR    = 5'h0D;
  localparam logic [ALU_W-1:0] ALU_AND   = 5'h0E;
  localparam logic [ALU_W-1:0] ALU_SLL   = 5'h0F;
  localparam logic [ALU_W-1:0] ALU_SRL   = 5'h10;
  localparam logic [ALU_W-1:0] ALU_SRA   = 5'h11;
  // M-extension ops are contiguous: mul, mulh, mulhsu, mulhu, div, divu, rem, remu
  localparam logic [ALU_W-1:0] ALU_MUL   = 5'h12;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic             alu_src;
    logic [5:0]       ext_op;
    logic [ALU_W-1:0] alu_op;
    logic [2:0]       npc_op;
    logic [1:0]       wd_sel;
    logic [2:0]       dm_ctrl;
    logic [4:0]       rd;
  } ctrl_t;

endpackage

// File: rtl/ctrl_dec.sv
// Combinational RV32I decoder; CTRL_MEXT_EN adds the funct7=0000001 multiply/divide group.
module ctrl_dec
  import ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        rs1_used,
  output logic        rs2_used,
  output logic        is_load,
  output logic        is_div,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  always_comb begin
    ctrl     = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    is_load  = 1'b0;
    is_div   = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000:  ctrl.alu_op = ALU_ADD;
              3'b001:  ctrl.alu_op = ALU_SLL;
              3'b010:  ctrl.alu_op = ALU_SLT;
              3'b011:  ctrl.alu_op = ALU_SLTU;
              3'b100:  ctrl.alu_op = ALU_XOR;
              3'b101:  ctrl.alu_op = ALU_SRL;
              3'b110:  ctrl.alu_op = ALU_OR;
              default: ctrl.alu_op = ALU_AND;
            endcase
          end
          7'b0100000: begin
            case (funct3)
              3'b000:  ctrl.alu_op = ALU_SUB;
              3'b101:  ctrl.alu_op = ALU_SRA;
              default: illegal = 1'b1;
            endcase
          end
`ifdef CTRL_MEXT_EN
          7'b0000001: begin
            ctrl.alu_op = ALU_MUL + ALU_W'(funct3);
            is_div      = funct3[2];
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.ext_op    = EXT_ITYPE;
        rs1_used       = 1'b1;
        case (funct3)
          3'b000: ctrl.alu_op = ALU_ADD;
          3'b010: ctrl.alu_op = ALU_SLT;
          3'b011: ctrl.alu_op = ALU_SLTU;
          3'b100: ctrl.alu_op = ALU_XOR;
          3'b110: ctrl.alu_op = ALU_OR;
          3'b111: ctrl.alu_op = ALU_AND;
          3'b001: begin
            ctrl.ext_op = EXT_ITYPE_SHAMT;
            ctrl.alu_op = ALU_SLL;
            illegal     = (funct7 != 7'b0000000);
          end
          default: begin
            ctrl.ext_op = EXT_ITYPE_SHAMT;
            ctrl.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            illegal     = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          end
        endcase
      end
      OP_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.ext_op    = EXT_ITYPE;
        ctrl.alu_op    = ALU_ADD;
        ctrl.wd_sel    = WD_MEM;
        rs1_used       = 1'b1;
        is_load        = 1'b1;
        case (funct3)
          3'b000:  ctrl.dm_ctrl = DM_BYTE;
          3'b001:  ctrl.dm_ctrl = DM_HALF;
          3'b010:  ctrl.dm_ctrl = DM_WORD;
          3'b100:  ctrl.dm_ctrl = DM_BYTE_U;
          3'b101:  ctrl.dm_ctrl = DM_HALF_U;
          default: illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.ext_op    = EXT_STYPE;
        ctrl.alu_op    = ALU_ADD;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
        case (funct3)
          3'b000:  ctrl.dm_ctrl = DM_BYTE;
          3'b001:  ctrl.dm_ctrl = DM_HALF;
          3'b010:  ctrl.dm_ctrl = DM_WORD;
          default: illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        ctrl.ext_op = EXT_BTYPE;
        ctrl.npc_op = NPC_BRANCH;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        case (funct3)
          3'b000:  ctrl.alu_op = ALU_SUB;
          3'b001:  ctrl.alu_op = ALU_BNE;
          3'b100:  ctrl.alu_op = ALU_BLT;
          3'b101:  ctrl.alu_op = ALU_BGE;
          3'b110:  ctrl.alu_op = ALU_BLTU;
          3'b111:  ctrl.alu_op = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.ext_op    = EXT_JTYPE;
        ctrl.npc_op    = NPC_JUMP;
        ctrl.wd_sel    = WD_PC;
      end
      OP_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.ext_op    = EXT_ITYPE;
        ctrl.alu_op    = ALU_ADD;
        ctrl.npc_op    = NPC_JALR;
        ctrl.wd_sel    = WD_PC;
        rs1_used       = 1'b1;
        illegal        = (funct3 != 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.ext_op    = EXT_UTYPE;
        ctrl.alu_op    = (opcode == OP_LUI) ? ALU_LUI : ALU_AUIPC;
      end
      default: illegal = 1'b1;
    endcase

    // Only writers carry a destination, so stores/branches never look like load-use producers.
    ctrl.rd = ctrl.reg_write ? inst[11:7] : 5'd0;

    if (illegal) begin
      ctrl     = '0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      is_load  = 1'b0;
      is_div   = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX control register with load-use and divide-occupancy stalls.
// Macro CTRL_MEXT_EN enables M-extension decode and the multi-cycle divide counter.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int DIV_LAT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        id_inst,
  input  logic               id_valid,
  input  logic               ex_flush,
  output logic               ex_RegWrite,
  output logic               ex_MemWrite,
  output logic               ex_ALUSrc,
  output logic [5:0]         ex_EXTOp,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic [2:0]         ex_NPCOp,
  output logic [1:0]         ex_WDSel,
  output logic [2:0]         ex_dm_ctrl,
  output logic [4:0]         ex_rd,
  output logic               ex_valid,
  output logic               ex_illegal,
  output logic               stall_if_id,
  output logic               mdu_busy
);

  if (DIV_LAT < 2 || DIV_LAT > 32) begin : g_bad_div_lat
    $error("ctrl_pipe: DIV_LAT must be within 2..32");
  end

  ctrl_t      dec_ctrl;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_rs1_used;
  logic       dec_rs2_used;
  logic       dec_is_load;
  logic       dec_is_div;
  logic       dec_illegal;

  ctrl_dec u_dec (
    .inst     (id_inst),
    .ctrl     (dec_ctrl),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rs1_used (dec_rs1_used),
    .rs2_used (dec_rs2_used),
    .is_load  (dec_is_load),
    .is_div   (dec_is_div),
    .illegal  (dec_illegal)
  );

  ctrl_t ex_ctrl;
  logic  ex_load;
  logic  load_use;

  assign load_use = ex_valid && ex_load && (ex_ctrl.rd != 5'd0) && id_valid &&
                    ((dec_rs1_used && (dec_rs1 == ex_ctrl.rd)) ||
                     (dec_rs2_used && (dec_rs2 == ex_ctrl.rd)));

  assign stall_if_id = (mdu_busy | load_use) & ~ex_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl    <= '0;
      ex_valid   <= 1'b0;
      ex_illegal <= 1'b0;
      ex_load    <= 1'b0;
    end else if (ex_flush || (!mdu_busy && (load_use || !id_valid))) begin
      ex_ctrl    <= '0;
      ex_valid   <= 1'b0;
      ex_illegal <= 1'b0;
      ex_load    <= 1'b0;
    end else if (!mdu_busy) begin
      ex_ctrl    <= dec_ctrl;
      ex_valid   <= 1'b1;
      ex_illegal <= dec_illegal;
      ex_load    <= dec_is_load;
    end
  end

`ifdef CTRL_MEXT_EN
  localparam logic [4:0] DIV_INIT = 5'(DIV_LAT - 1);

  // Counts the remaining EX cycles of a divide; non-zero means EX is occupied.
  logic [4:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= 5'd0;
    end else if (ex_flush) begin
      div_cnt <= 5'd0;
    end else if (div_cnt != 5'd0) begin
      div_cnt <= div_cnt - 5'd1;
    end else if (!load_use && id_valid && dec_is_div) begin
      div_cnt <= DIV_INIT;
    end
  end

  assign mdu_busy = (div_cnt != 5'd0);
`else
  logic unused_div;
  assign unused_div = dec_is_div;
  assign mdu_busy   = 1'b0;
`endif

  assign ex_RegWrite = ex_ctrl.reg_write;
  assign ex_MemWrite = ex_ctrl.mem_write;
  assign ex_ALUSrc   = ex_ctrl.alu_src;
  assign ex_EXTOp    = ex_ctrl.ext_op;
  assign ex_ALUOp    = ALUOP_W'(ex_ctrl.alu_op);
  assign ex_NPCOp    = ex_ctrl.npc_op;
  assign ex_WDSel    = ex_ctrl.wd_sel;
  assign ex_dm_ctrl  = ex_ctrl.dm_ctrl;
  assign ex_rd       = ex_ctrl.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: each step pushes the expected ID/EX contents and
// checks them after the capturing edge, plus the stall/busy flags before it.
module tb_ctrl_pipe;

  localparam int W = 29;

  logic        clk;
  logic        rst;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        ex_flush;
  logic        ex_RegWrite;
  logic        ex_MemWrite;
  logic        ex_ALUSrc;
  logic [5:0]  ex_EXTOp;
  logic [4:0]  ex_ALUOp;
  logic [2:0]  ex_NPCOp;
  logic [1:0]  ex_WDSel;
  logic [2:0]  ex_dm_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_valid;
  logic        ex_illegal;
  logic        stall_if_id;
  logic        mdu_busy;

  logic [W-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  ctrl_pipe #(.ALUOP_W(5), .DIV_LAT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_inst     (id_inst),
    .id_valid    (id_valid),
    .ex_flush    (ex_flush),
    .ex_RegWrite (ex_RegWrite),
    .ex_MemWrite (ex_MemWrite),
    .ex_ALUSrc   (ex_ALUSrc),
    .ex_EXTOp    (ex_EXTOp),
    .ex_ALUOp    (ex_ALUOp),
    .ex_NPCOp    (ex_NPCOp),
    .ex_WDSel    (ex_WDSel),
    .ex_dm_ctrl  (ex_dm_ctrl),
    .ex_rd       (ex_rd),
    .ex_valid    (ex_valid),
    .ex_illegal  (ex_illegal),
    .stall_if_id (stall_if_id),
    .mdu_busy    (mdu_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ev(input logic v, input logic il, input logic rw,
                                      input logic mw, input logic as, input logic [5:0] ext,
                                      input logic [4:0] alu, input logic [2:0] npc,
                                      input logic [1:0] wd, input logic [2:0] dm,
                                      input logic [4:0] rd);
    return {v, il, rw, mw, as, ext, alu, npc, wd, dm, rd};
  endfunction

  function automatic logic [W-1:0] ex_vec();
    return {ex_valid, ex_illegal, ex_RegWrite, ex_MemWrite, ex_ALUSrc, ex_EXTOp,
            ex_ALUOp, ex_NPCOp, ex_WDSel, ex_dm_ctrl, ex_rd};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // driver + scoreboard step: drive ID, check stall/busy, check EX after the edge
  task automatic step(input string tag, input logic [31:0] inst, input logic v,
                      input logic f, input logic exp_stall, input logic exp_busy,
                      input logic [W-1:0] exp_ex);
    @(negedge clk);
    id_inst  = inst;
    id_valid = v;
    ex_flush = f;
    exp_q.push_back(exp_ex);
    #1;
    check({tag, "_stall"}, W'(stall_if_id), W'(exp_stall));
    check({tag, "_busy"}, W'(mdu_busy), W'(exp_busy));
    @(posedge clk);
    #1;
    check({tag, "_ex"}, ex_vec(), exp_q.pop_front());
  endtask

  localparam logic [31:0] I_ADDI  = {12'd5, 5'd2, 3'b000, 5'd1, 7'b0010011};
  localparam logic [31:0] I_ADD   = {7'b0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] I_ADD0  = {7'b0, 5'd2, 5'd0, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] I_SUB   = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011};
  localparam logic [31:0] I_XOR   = {7'b0, 5'd12, 5'd11, 3'b100, 5'd10, 7'b0110011};
  localparam logic [31:0] I_SRAI  = {7'b0100000, 5'd3, 5'd4, 3'b101, 5'd4, 7'b0010011};
  localparam logic [31:0] I_LW5   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] I_LW0   = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
  localparam logic [31:0] I_LBU   = {12'd0, 5'd1, 3'b100, 5'd8, 7'b0000011};
  localparam logic [31:0] I_SW5   = {7'b0, 5'd5, 5'd9, 3'b010, 5'd0, 7'b0100011};
  localparam logic [31:0] I_SB    = {7'b0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b0100011};
  localparam logic [31:0] I_LUI28 = {20'h00028, 5'd3, 7'b0110111};
  localparam logic [31:0] I_BEQ   = {7'b0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
  localparam logic [31:0] I_BLTU  = {7'b0, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011};
  localparam logic [31:0] I_JAL   = {20'h00000, 5'd1, 7'b1101111};
  localparam logic [31:0] I_JALR  = {12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111};
  localparam logic [31:0] I_AUIPC = {20'h00001, 5'd9, 7'b0010111};
  localparam logic [31:0] I_BAD   = {25'd0, 7'h7F};
  localparam logic [31:0] I_MUL   = {7'b0000001, 5'd5, 5'd4, 3'b000, 5'd3, 7'b0110011};
  localparam logic [31:0] I_DIV   = {7'b0000001, 5'd5, 5'd4, 3'b100, 5'd3, 7'b0110011};

  logic [W-1:0] e_addi, e_add, e_div;

  initial begin
    e_addi = ev(1, 0, 1, 0, 1, 6'b010000, 5'h03, 3'b000, 2'b00, 3'b000, 5'd1);
    e_add  = ev(1, 0, 1, 0, 0, 6'b000000, 5'h03, 3'b000, 2'b00, 3'b000, 5'd6);
    e_div  = ev(1, 0, 1, 0, 0, 6'b000000, 5'h16, 3'b000, 2'b00, 3'b000, 5'd3);

    rst      = 1'b1;
    id_inst  = I_ADDI;
    id_valid = 1'b1;
    ex_flush = 1'b0;
    #2;
    check("reset_ex", ex_vec(), '0);
    check("reset_stall", W'(stall_if_id), '0);
    check("reset_busy", W'(mdu_busy), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    step("addi", I_ADDI, 1, 0, 0, 0, e_addi);
    step("add", I_ADD, 1, 0, 0, 0, e_add);
    step("sub", I_SUB, 1, 0, 0, 0, ev(1, 0, 1, 0, 0, 6'b0, 5'h04, 3'b000, 2'b00, 3'b000, 5'd7));
    step("xor", I_XOR, 1, 0, 0, 0, ev(1, 0, 1, 0, 0, 6'b0, 5'h0C, 3'b000, 2'b00, 3'b000, 5'd10));
    step("srai", I_SRAI, 1, 0, 0, 0, ev(1, 0, 1, 0, 1, 6'b100000, 5'h11, 3'b000, 2'b00, 3'b000, 5'd4));

    // load-use on rs1: one stall, one bubble, then capture
    step("lw_x5", I_LW5, 1, 0, 0, 0, ev(1, 0, 1, 0, 1, 6'b010000, 5'h03, 3'b000, 2'b01, 3'b000, 5'd5));
    step("lu_add_stall", I_ADD, 1, 0, 1, 0, '0);
    step("lu_add_cap", I_ADD, 1, 0, 0, 0, e_add);

    // x0 destination never creates a hazard
    step("lw_x0", I_LW0, 1, 0, 0, 0, ev(1, 0, 1, 0, 1, 6'b010000, 5'h03, 3'b000, 2'b01, 3'b000, 5'd0));
    step("add_x0", I_ADD0, 1, 0, 0, 0, e_add);

    // load-use on rs2 of a store
    step("lw_x5b", I_LW5, 1, 0, 0, 0, ev(1, 0, 1, 0, 1, 6'b010000, 5'h03, 3'b000, 2'b01, 3'b000, 5'd5));
    step("lu_sw_stall", I_SW5, 1, 0, 1, 0, '0);
    step("lu_sw_cap", I_SW5, 1, 0, 0, 0, ev(1, 0, 0, 1, 1, 6'b001000, 5'h03, 3'b000, 2'b00, 3'b000, 5'd0));

    // lui's rs1 field matches x5 but rs1 is not used
    step("lw_x5c", I_LW5, 1, 0, 0, 0, ev(1, 0, 1, 0, 1, 6'b010000, 5'h03, 3'b000, 2'b01, 3'b000, 5'd5));
    step("lui_nostall", I_LUI28, 1, 0, 0, 0, ev(1, 0, 1, 0, 1, 6'b000010, 5'h01, 3'b000, 2'b00, 3'b000, 5'd3));

    step("lbu", I_LBU, 1, 0, 0, 0, ev(1, 0, 1, 0, 1, 6'b010000, 5'h03, 3'b000, 2'b01, 3'b100, 5'd8));
    step("sb", I_SB, 1, 0, 0, 0, ev(1, 0, 0, 1, 1, 6'b001000, 5'h03, 3'b000, 2'b00, 3'b011, 5'd0));

    // taken branch flushes the ID instruction
    step("beq", I_BEQ, 1, 0, 0, 0, ev(1, 0, 0, 0, 0, 6'b000100, 5'h04, 3'b001, 2'b00, 3'b000, 5'd0));
    step("flush_addi", I_ADDI, 1, 1, 0, 0, '0);

    // flush masks a pending load-use stall
    step("lw_x5d", I_LW5, 1, 0, 0, 0, ev(1, 0, 1, 0, 1, 6'b010000, 5'h03, 3'b000, 2'b01, 3'b000, 5'd5));
    step("flush_lu", I_ADD, 1, 1, 0, 0, '0);

    step("bltu", I_BLTU, 1, 0, 0, 0, ev(1, 0, 0, 0, 0, 6'b000100, 5'h08, 3'b001, 2'b00, 3'b000, 5'd0));
    step("jal", I_JAL, 1, 0, 0, 0, ev(1, 0, 1, 0, 0, 6'b000001, 5'h00, 3'b010, 2'b10, 3'b000, 5'd1));
    step("jalr", I_JALR, 1, 0, 0, 0, ev(1, 0, 1, 0, 1, 6'b010000, 5'h03, 3'b100, 2'b10, 3'b000, 5'd1));
    step("auipc", I_AUIPC, 1, 0, 0, 0, ev(1, 0, 1, 0, 1, 6'b000010, 5'h02, 3'b000, 2'b00, 3'b000, 5'd9));

    step("illegal_7f", I_BAD, 1, 0, 0, 0, ev(1, 1, 0, 0, 0, 6'b0, 5'h00, 3'b000, 2'b00, 3'b000, 5'd0));
    step("id_bubble", I_ADDI, 0, 0, 0, 0, '0);

`ifdef CTRL_MEXT_EN
    step("mul", I_MUL, 1, 0, 0, 0, ev(1, 0, 1, 0, 0, 6'b0, 5'h12, 3'b000, 2'b00, 3'b000, 5'd3));
    step("after_mul", I_ADDI, 1, 0, 0, 0, e_addi);

    step("div", I_DIV, 1, 0, 0, 0, e_div);
    for (int i = 1; i <= 7; i++) begin
      step($sformatf("div_busy%0d", i), I_ADDI, 1, 0, 1, 1, e_div);
    end
    step("div_next_cap", I_ADDI, 1, 0, 0, 0, e_addi);

    step("div2", I_DIV, 1, 0, 0, 0, e_div);
    step("div2_busy1", I_ADDI, 1, 0, 1, 1, e_div);
    step("div2_busy2", I_ADDI, 1, 0, 1, 1, e_div);
    step("div2_flush", I_ADDI, 1, 1, 0, 1, '0);
    step("div2_after", I_ADDI, 1, 0, 0, 0, e_addi);
`else
    step("mul_illegal", I_MUL, 1, 0, 0, 0, ev(1, 1, 0, 0, 0, 6'b0, 5'h00, 3'b000, 2'b00, 3'b000, 5'd0));
    step("div_illegal", I_DIV, 1, 0, 0, 0, ev(1, 1, 0, 0, 0, 6'b0, 5'h00, 3'b000, 2'b00, 3'b000, 5'd0));
`endif

    // asynchronous reset in the middle of a load-use stall
    step("lw_x5e", I_LW5, 1, 0, 0, 0, ev(1, 0, 1, 0, 1, 6'b010000, 5'h03, 3'b000, 2'b01, 3'b000, 5'd5));
    @(negedge clk);
    id_inst = I_ADD;
    #1;
    check("midrst_pre_stall", W'(stall_if_id), W'(1'b1));
    rst = 1'b1;
    #1;
    check("midrst_ex", ex_vec(), '0);
    check("midrst_stall", W'(stall_if_id), '0);
    check("midrst_busy", W'(mdu_busy), '0);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_add", I_ADD, 1, 0, 0, 0, e_add);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
